// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and helpers for the memory controller
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [6:0] OPCODE_L = 7'b0000011;
    localparam logic [6:0] OPCODE_S = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } mem_state_t;

    // Size 11 has no RISC-V meaning here and is handled as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                                input logic [1:0]  size,
                                                input logic        uns);
        case (size)
            SZ_B:    return uns ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            SZ_H:    return uns ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

endpackage

// File: rtl/mem_req_slot.sv
// rtl/mem_req_slot.sv - single-entry pending request latch for one requester port
module mem_req_slot #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic                  we,
    input  logic [2:0]            funct,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] src,
    input  logic                  take,
    input  logic                  clear,
    output logic                  avail,
    output logic                  req_we,
    output logic [2:0]            req_funct,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [DATA_WIDTH-1:0] req_src
);

    logic                  full;
    logic                  taken;
    logic                  s_we;
    logic [2:0]            s_funct;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic [DATA_WIDTH-1:0] s_src;
    logic                  accept;
    logic                  unused_addr_hi;

    // A pulse while the slot is occupied (pending or in service) is dropped.
    assign accept = valid & ~full;
    assign avail  = (full & ~taken) | accept;

    assign req_we    = full ? s_we    : we;
    assign req_funct = full ? s_funct : funct;
    assign req_addr  = full ? s_addr  : addr[ADDR_WIDTH-1:0];
    assign req_src   = full ? s_src   : src;

    assign unused_addr_hi = ^addr[DATA_WIDTH-1:ADDR_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full    <= 1'b0;
            taken   <= 1'b0;
            s_we    <= 1'b0;
            s_funct <= 3'b000;
            s_addr  <= '0;
            s_src   <= '0;
        end else if (clear) begin
            full  <= 1'b0;
            taken <= 1'b0;
        end else begin
            if (accept) begin
                full    <= 1'b1;
                s_we    <= we;
                s_funct <= funct;
                s_addr  <= addr[ADDR_WIDTH-1:0];
                s_src   <= src;
            end
            if (take) begin
                taken <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - arbitrates load/store and fetch ports onto a byte-wide synchronous RAM
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ls_valid,
    input  logic                  ls_we,
    input  logic [2:0]            ls_funct,
    input  logic [DATA_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_src,
    output logic                  ls_done,
    output logic [DATA_WIDTH-1:0] ls_data,
    input  logic                  if_valid,
    input  logic [DATA_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [DATA_WIDTH-1:0] if_data,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr
);

    mem_state_t state, state_n;

    logic                  ls_avail, ls_take, ls_clear, ls_req_we;
    logic [2:0]            ls_req_funct;
    logic [ADDR_WIDTH-1:0] ls_req_addr;
    logic [DATA_WIDTH-1:0] ls_req_src;
    logic                  if_avail, if_take, if_clear, if_req_we;
    logic [2:0]            if_req_funct;
    logic [ADDR_WIDTH-1:0] if_req_addr;
    logic [DATA_WIDTH-1:0] if_req_src;

    logic                  sel_we;
    logic [2:0]            sel_funct;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_src;

    logic                  cur_port;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] cur_src;
    logic [1:0]            cur_size;
    logic                  cur_uns;
    logic [2:0]            cur_n;
    logic [2:0]            idx;
    logic [2:0]            rd;
    logic                  rd_ph;
    logic [31:0]           acc;
    logic [31:0]           assembled;
    logic                  issue, capture, finish;

    mem_req_slot #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ls_slot (
        .clk(clk), .rst(rst), .valid(ls_valid), .we(ls_we), .funct(ls_funct),
        .addr(ls_addr), .src(ls_src), .take(ls_take), .clear(ls_clear),
        .avail(ls_avail), .req_we(ls_req_we), .req_funct(ls_req_funct),
        .req_addr(ls_req_addr), .req_src(ls_req_src)
    );

    mem_req_slot #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_if_slot (
        .clk(clk), .rst(rst), .valid(if_valid), .we(1'b0), .funct({1'b0, SZ_W}),
        .addr(if_addr), .src('0), .take(if_take), .clear(if_clear),
        .avail(if_avail), .req_we(if_req_we), .req_funct(if_req_funct),
        .req_addr(if_req_addr), .req_src(if_req_src)
    );

    assign sel_we    = ls_avail ? ls_req_we    : if_req_we;
    assign sel_funct = ls_avail ? ls_req_funct : if_req_funct;
    assign sel_addr  = ls_avail ? ls_req_addr  : if_req_addr;
    assign sel_src   = ls_avail ? ls_req_src   : if_req_src;

    assign ls_clear = finish & ~cur_port;
    assign if_clear = finish &  cur_port;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        ls_take   = 1'b0;
        if_take   = 1'b0;
        issue     = 1'b0;
        capture   = 1'b0;
        finish    = 1'b0;
        assembled = acc;
        assembled[{rd[1:0], 3'b000} +: 8] = mem_din;
        case (state)
            IDLE: begin
                if (ls_avail) begin
                    ls_take = 1'b1;
                    state_n = ls_req_we ? WRITE : READ;
                end else if (if_avail) begin
                    if_take = 1'b1;
                    state_n = if_req_we ? WRITE : READ;
                end
            end
            READ: begin
                // Captures trail address issue by one cycle (RAM read latency).
                issue   = idx < cur_n;
                capture = rd_ph;
                if (rd_ph && rd == cur_n - 3'd1) begin
                    finish  = 1'b1;
                    state_n = IDLE;
                end
            end
            WRITE: begin
                issue = idx < cur_n;
                if (!issue) begin
                    finish  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_port <= 1'b0;
            cur_addr <= '0;
            cur_src  <= '0;
            cur_size <= 2'b00;
            cur_uns  <= 1'b0;
            cur_n    <= 3'd0;
            idx      <= 3'd0;
            rd       <= 3'd0;
            rd_ph    <= 1'b0;
            acc      <= 32'h0;
            mem_a    <= '0;
            mem_wr   <= 1'b0;
            mem_dout <= 8'h00;
            ls_done  <= 1'b0;
            ls_data  <= '0;
            if_done  <= 1'b0;
            if_data  <= '0;
        end else begin
            ls_done <= 1'b0;
            if_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ls_take || if_take) begin
                        cur_port <= if_take;
                        cur_addr <= sel_addr;
                        cur_src  <= sel_src;
                        cur_size <= sel_funct[1:0];
                        cur_uns  <= sel_funct[2];
                        cur_n    <= size_bytes(sel_funct[1:0]);
                        mem_a    <= sel_addr;
                        mem_wr   <= sel_we;
                        mem_dout <= sel_we ? sel_src[7:0] : 8'h00;
                        idx      <= 3'd1;
                        rd       <= 3'd0;
                        rd_ph    <= 1'b0;
                        acc      <= 32'h0;
                    end
                end
                READ: begin
                    rd_ph <= 1'b1;
                    if (issue) begin
                        mem_a <= cur_addr + ADDR_WIDTH'(idx);
                        idx   <= idx + 3'd1;
                    end
                    if (capture) begin
                        acc[{rd[1:0], 3'b000} +: 8] <= mem_din;
                        rd <= rd + 3'd1;
                    end
                    if (finish) begin
                        if (cur_port) begin
                            if_done <= 1'b1;
                            if_data <= assembled;
                        end else begin
                            ls_done <= 1'b1;
                            ls_data <= load_extend(assembled, cur_size, cur_uns);
                        end
                    end
                end
                WRITE: begin
                    if (issue) begin
                        mem_a    <= cur_addr + ADDR_WIDTH'(idx);
                        mem_dout <= cur_src[{idx[1:0], 3'b000} +: 8];
                        idx      <= idx + 3'd1;
                    end else begin
                        mem_wr   <= 1'b0;
                        mem_dout <= 8'h00;
                        if (cur_port) begin
                            if_done <= 1'b1;
                            if_data <= '0;
                        end else begin
                            ls_done <= 1'b1;
                            ls_data <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
